tx_fifo: RTL and testbench

Transmit FIFO for one state machine: buffers 32-bit words written by the system bus and presents them to the output shift register, which consumes them on PULL or autopull. Data is first-word-fall-through: the head word is always visible on `rd_data`, and the consumer pops it in the same cycle it samples it. Sticky overflow and underflow flags support debug, and an optional join mode doubles the depth.

---
 rtl/tx_fifo.sv | 103 ++++++++++
 tb/tb_tx_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tx_fifo.sv
// Transmit FIFO, first-word-fall-through, with sticky overflow/underflow flags.
// Define TX_FIFO_JOIN_EN to add join mode (port join_mode, since "join" is a reserved word).
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(2*DEPTH)+1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   wr_data,
  input  logic          wr_en,
  output logic [31:0]   rd_data,
  input  logic          rd_en,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  input  logic          flush,
  output logic          overflow,
  output logic          underflow,
  input  logic          clr_over,
`ifdef TX_FIFO_JOIN_EN
  input  logic          clr_under,
  input  logic          join_mode
`else
  input  logic          clr_under
`endif
);

`ifdef TX_FIFO_JOIN_EN
  localparam int MEM = 2*DEPTH;
`else
  localparam int MEM = DEPTH;
`endif
  localparam int AW = $clog2(MEM);

  logic [31:0]   mem [MEM];
  logic [LW-1:0] wptr_reg, rptr_reg;
  logic [LW-1:0] cap;
  logic [AW-1:0] amask, waddr, raddr;
  logic          flush_all, do_push, do_pop, set_over, set_under;

`ifdef TX_FIFO_JOIN_EN
  logic join_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) join_reg <= 1'b0;
    else     join_reg <= join_mode;
  end

  // A change of mode discards contents so the old layout never leaks into the new capacity.
  assign flush_all = flush | (join_mode != join_reg);
  assign cap       = join_reg ? LW'(2*DEPTH) : LW'(DEPTH);
  assign amask     = join_reg ? AW'(2*DEPTH-1) : AW'(DEPTH-1);
`else
  assign flush_all = flush;
  assign cap       = LW'(DEPTH);
  assign amask     = AW'(DEPTH-1);
`endif

  assign level = wptr_reg - rptr_reg;
  assign full  = (level == cap);
  assign empty = (level == '0);
  assign waddr = wptr_reg[AW-1:0] & amask;
  assign raddr = rptr_reg[AW-1:0] & amask;

  assign rd_data = empty ? 32'h0 : mem[raddr];

  // A pop on a full FIFO frees the slot the same-edge push lands in.
  assign do_pop    = rd_en & ~empty;
  assign do_push   = wr_en & (~full | rd_en);
  assign set_over  = ~flush_all & wr_en & full & ~rd_en;
  assign set_under = ~flush_all & rd_en & empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else if (flush_all) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (do_push) wptr_reg <= wptr_reg + LW'(1);
      if (do_pop)  rptr_reg <= rptr_reg + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_all && do_push) mem[waddr] <= wr_data;
  end

  // Set wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (set_over)      overflow <= 1'b1;
      else if (clr_over) overflow <= 1'b0;
      if (set_under)      underflow <= 1'b1;
      else if (clr_under) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_fifo.sv
// Directed self-checking bench for tx_fifo; join-mode checks run only with TX_FIFO_JOIN_EN.
module tb_tx_fifo;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(2*DEPTH)+1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   wr_data = '0;
  logic          wr_en = 1'b0;
  logic [31:0]   rd_data;
  logic          rd_en = 1'b0;
  logic          full, empty;
  logic [LW-1:0] level;
  logic          flush = 1'b0;
  logic          overflow, underflow;
  logic          clr_over = 1'b0;
  logic          clr_under = 1'b0;
`ifdef TX_FIFO_JOIN_EN
  logic          join_mode = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q[$];

  tx_fifo #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .rd_data(rd_data),
    .rd_en(rd_en), .full(full), .empty(empty), .level(level), .flush(flush),
    .overflow(overflow), .underflow(underflow), .clr_over(clr_over),
`ifdef TX_FIFO_JOIN_EN
    .clr_under(clr_under), .join_mode(join_mode)
`else
    .clr_under(clr_under)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    $display("t=%0t wr_en=%0b wr=%08h rd_en=%0b flush=%0b -> lvl=%0d rd=%08h full=%0b empty=%0b ovf=%0b unf=%0b",
             $time, wr_en, wr_data, rd_en, flush, level, rd_data, full, empty, overflow, underflow);
  endtask

  task automatic push(input logic [31:0] d);
    wr_en = 1'b1; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  initial begin
    #12;
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_full", 32'(full), 32'd0);
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_rd_data", rd_data, 32'h0);
    check_val("rst_flags", {30'd0, overflow, underflow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
    check_val("fill_full", 32'(full), 32'd1);
    check_val("fill_level", 32'(level), 32'd4);
    check_val("fill_head", rd_data, 32'hA0);

    // Overflow
    push(32'hDEAD);
    check_val("ovf_flag", 32'(overflow), 32'd1);
    check_val("ovf_level", 32'(level), 32'd4);
    check_val("ovf_head", rd_data, 32'hA0);
    clr_over = 1'b1; cycle(); clr_over = 1'b0;
    check_val("ovf_clear", 32'(overflow), 32'd0);

    // Full push+pop with wrap
    q = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
    for (int k = 0; k < 10; k++) begin
      check_val("wrap_head_pre", rd_data, q[0]);
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hB4 + 32'(k);
      cycle();
      void'(q.pop_front());
      q.push_back(32'hB4 + 32'(k));
      check_val("wrap_level", 32'(level), 32'd4);
      check_val("wrap_head", rd_data, q[0]);
    end
    wr_en = 1'b0;

    // Drain
    while (q.size() > 0) begin
      check_val("drain_data", rd_data, q[0]);
      rd_en = 1'b1;
      cycle();
      void'(q.pop_front());
    end
    rd_en = 1'b0;
    check_val("drain_empty", 32'(empty), 32'd1);
    check_val("drain_rd_zero", rd_data, 32'h0);
    check_val("drain_no_under", 32'(underflow), 32'd0);

    // Underflow, then push+pop on empty
    rd_en = 1'b1; cycle(); rd_en = 1'b0;
    check_val("unf_flag", 32'(underflow), 32'd1);
    check_val("unf_level", 32'(level), 32'd0);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h55;
    cycle();
    wr_en = 1'b0; rd_en = 1'b0;
    check_val("emp_pp_level", 32'(level), 32'd1);
    check_val("emp_pp_data", rd_data, 32'h55);
    rd_en = 1'b1; clr_under = 1'b1; cycle(); rd_en = 1'b0; clr_under = 1'b0;
    check_val("unf_clear", 32'(underflow), 32'd0);
    check_val("unf_pop_empty", 32'(empty), 32'd1);

    // Flush with concurrent push
    for (int i = 0; i < 3; i++) push(32'hC0 + 32'(i));
    check_val("fl_level3", 32'(level), 32'd3);
    flush = 1'b1; wr_en = 1'b1; wr_data = 32'hCC;
    cycle();
    flush = 1'b0; wr_en = 1'b0;
    check_val("fl_level", 32'(level), 32'd0);
    check_val("fl_empty", 32'(empty), 32'd1);
    check_val("fl_flags", {30'd0, overflow, underflow}, 32'd0);

    // Asynchronous reset mid-cycle
    rd_en = 1'b1; cycle(); rd_en = 1'b0;
    push(32'hE0); push(32'hE1);
    check_val("ar_level2", 32'(level), 32'd2);
    check_val("ar_unf_set", 32'(underflow), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("ar_level", 32'(level), 32'd0);
    check_val("ar_empty", 32'(empty), 32'd1);
    check_val("ar_rd_data", rd_data, 32'h0);
    check_val("ar_unf", 32'(underflow), 32'd0);
    cycle();
    rst = 1'b0;
    push(32'hD0);
    check_val("post_rst_data", rd_data, 32'hD0);
    check_val("post_rst_level", 32'(level), 32'd1);

`ifdef TX_FIFO_JOIN_EN
    push(32'hD1);
    check_val("jn_level2", 32'(level), 32'd2);
    join_mode = 1'b1; cycle();
    check_val("jn_flushed", 32'(empty), 32'd1);
    for (int i = 0; i < 8; i++) begin
      push(32'hF0 + 32'(i));
      check_val("jn_full", 32'(full), (i == 7) ? 32'd1 : 32'd0);
    end
    check_val("jn_level8", 32'(level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_val("jn_data", rd_data, 32'hF0 + 32'(i));
      rd_en = 1'b1; cycle(); rd_en = 1'b0;
    end
    check_val("jn_empty", 32'(empty), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
